// File: rtl/tdc_axi_lite_slave_regs.sv
// tdc_axi_lite_slave_regs
//   AXI4-Lite register file for the TDC_v2 core. It holds four RW config/scratch
//   registers, one RO status word, and a timestamp FIFO that is popped by reading
//   the TS_POP address.
// Ports
//   s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, write data, write response
//   s_axi_ar* / s_axi_r*            : read address, read data
//   ts_data / ts_valid : timestamp push port from the TDC datapath
//   ctrl_out           : live value of REG0
// Register map (byte address)
//   0x00-0x0C REG0-3 (RW, byte strobes), 0x10 STATUS (RO),
//   0x14 TS_POP (RO, a read pops the FIFO); anything else is SLVERR.
// Handshake rule: a transfer on any channel happens on the rising clock edge
//   where both valid and ready are high. A source holds valid and payload until
//   that edge. Every ready/valid output here is a flop.
module tdc_axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int TS_FIFO_DEPTH      = 8
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [31:0]                     ts_data,
  input  logic                            ts_valid,
  output logic [31:0]                     ctrl_out
);

  localparam int PW = $clog2(TS_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TS_FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]  awidx_q, awidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  logic        ovf_q, ovf_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] mem_q [TS_FIFO_DEPTH];

  logic          aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic [2:0]    wr_idx, rd_sel;
  logic [31:0]   wr_data, status_word, fifo_head;
  logic [3:0]    wr_strb;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, pop, push, ovf_clr;
  logic          unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs   = s_axi_awvalid & awready_q;
  assign w_hs    = s_axi_wvalid & wready_q;
  assign ar_hs   = s_axi_arvalid & arready_q;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q | w_hs;
  // The write may execute in the same cycle as the later handshake, so pick
  // the live bus value when that half has not been captured yet.
  assign wr_idx  = aw_held_q ? awidx_q : s_axi_awaddr[4:2];
  assign wr_data = w_held_q ? wdata_q : s_axi_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
  assign rd_sel  = s_axi_araddr[4:2];

  // Write channel
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    ovf_clr   = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axi_awaddr[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_have && w_have) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          if (!wr_idx[2]) begin
            bresp_d = RESP_OKAY;
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) regs_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
            end
            if (wr_idx == 3'd0 && wr_strb[3] && wr_data[31]) ovf_clr = 1'b1;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Timestamp FIFO bookkeeping
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == DEPTH_C);
  assign fifo_head   = mem_q[rd_ptr_q[PW-1:0]];
  assign status_word = {23'b0, ovf_q, 4'b0, 4'(fifo_count)};
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push        = ts_valid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ts_valid && fifo_full && !pop) ovf_d = 1'b1;
  end

  // Read channel
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pop       = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_OKAY;
          case (rd_sel)
            3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[rd_sel[1:0]];
            3'd4: rdata_d = status_word;
            3'd5: begin
              if (fifo_empty) begin
                rdata_d = 32'hDEAD_0000;
              end else begin
                rdata_d = fifo_head;
                pop     = 1'b1;
              end
            end
            default: begin
              rdata_d = 32'h0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = !rvalid_d;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge s_axi_aclk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= ts_data;
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_out      = regs_q[0];

endmodule

// File: tb/tb_tdc_axi_lite_slave_regs.sv
// Bench for tdc_axi_lite_slave_regs: register read/write, write-channel
// ordering, byte strobes, timestamp FIFO, error responses and async reset.
module tb_tdc_axi_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [4:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] ts_data = '0;
  logic        ts_valid = 1'b0;
  logic [31:0] ctrl_out;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected read data queued when stimulus is driven.
  logic [31:0] exp_q[$];
  // Reference model of the timestamp FIFO.
  logic [31:0] model_fifo[$];
  bit          model_ovf = 1'b0;

  tdc_axi_lite_slave_regs dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ts_data(ts_data), .ts_valid(ts_valid), .ctrl_out(ctrl_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    bit aw_fire, w_fire, b_fire;
    ok = 1'b0;
    resp = 2'b11;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      b_fire  = s_axi_bvalid && s_axi_bready;
      if (b_fire) resp = s_axi_bresp;
      @(posedge clk);
      @(negedge clk);
      if (aw_fire) s_axi_awvalid = 1'b0;
      if (w_fire) s_axi_wvalid = 1'b0;
      if (b_fire) begin
        s_axi_bready = 1'b0;
        ok = 1'b1;
      end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit ar_fire, r_fire;
    ok = 1'b0;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ar_fire = s_axi_arvalid && s_axi_arready;
      r_fire  = s_axi_rvalid && s_axi_rready;
      if (r_fire) begin
        data = s_axi_rdata;
        resp = s_axi_rresp;
      end
      @(posedge clk);
      @(negedge clk);
      if (ar_fire) s_axi_arvalid = 1'b0;
      if (r_fire) begin
        s_axi_rready = 1'b0;
        ok = 1'b1;
      end
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic push_ts(input logic [31:0] data);
    @(negedge clk);
    ts_data = data; ts_valid = 1'b1;
    if (model_fifo.size() < 8) model_fifo.push_back(data);
    else model_ovf = 1'b1;
    @(negedge clk);
    ts_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_status();
    model_status = {23'b0, model_ovf, 4'b0, 4'(model_fifo.size())};
  endfunction

  // Write with expected-response check.
  task automatic write_chk(input string name, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    bit ok;
    axi_write(addr, data, strb, resp, ok);
    n_checks++;
    if (!ok || resp !== exp_resp) begin
      n_errors++;
      $display("FAIL %s bresp: got %b (done=%0d) want %b", name, resp, ok, exp_resp);
    end
  endtask

  // Read: expected value queued, then popped when the R beat arrives.
  task automatic read_chk(input string name, input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    logic [31:0] data, exp;
    logic [1:0]  resp;
    bit ok;
    exp_q.push_back(exp_data);
    axi_read(addr, data, resp, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || data !== exp || resp !== exp_resp) begin
      n_errors++;
      $display("FAIL %s read: got %h/%b (done=%0d) want %h/%b", name, data, resp, ok, exp, exp_resp);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: got %b want 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    n_checks++;
    if (s_axi_rdata !== 32'h0 || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_data: got rdata=%h bresp=%b rresp=%b want 0", s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    n_checks++;
    if (ctrl_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ctrl_out: got %h want 00000000", ctrl_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_rearm: got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    read_chk("reset_status", 5'h10, 32'h0, 2'b00);
  endtask

  task automatic test_rw_basic();
    logic [31:0] vals [4];
    vals = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < 4; i++) write_chk("rw_write", 5'(i * 4), vals[i], 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) read_chk("rw_read", 5'(i * 4), vals[i], 2'b00);
    n_checks++;
    if (ctrl_out !== 32'h0101FFFF) begin
      n_errors++;
      $display("FAIL rw_ctrl_out: got %h want 0101ffff", ctrl_out);
    end
  endtask

  task automatic test_aw_before_w();
    @(negedge clk);
    s_axi_awaddr = 5'h0C; s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
    n_checks++;
    if (s_axi_awready !== 1'b1) begin n_errors++; $display("FAIL order_awready_idle: got %b want 1", s_axi_awready); end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010) begin
      n_errors++;
      $display("FAIL order_after_aw: got aw/w/b=%b want 010", {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    @(negedge clk);
    n_checks++;
    if (s_axi_bvalid !== 1'b0) begin n_errors++; $display("FAIL order_no_early_b: got %b want 0", s_axi_bvalid); end
    @(negedge clk);
    s_axi_wdata = 32'hC0FFEE00; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b001) begin
        n_errors++;
        $display("FAIL order_bhold_%0d: got aw/w/b=%b want 001", c, {s_axi_awready, s_axi_wready, s_axi_bvalid});
      end
      @(negedge clk);
    end
    n_checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      n_errors++;
      $display("FAIL order_b_before_ready: got bvalid=%b bresp=%b want 1/00", s_axi_bvalid, s_axi_bresp);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b110) begin
      n_errors++;
      $display("FAIL order_rearm: got aw/w/b=%b want 110", {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    read_chk("order_readback", 5'h0C, 32'hC0FFEE00, 2'b00);
  endtask

  task automatic test_wstrb();
    write_chk("strb_write", 5'h04, 32'h12345678, 4'b0101, 2'b00);
    read_chk("strb_read", 5'h04, 32'hab340078, 2'b00);
  endtask

  task automatic test_fifo_basic();
    push_ts(32'h10);
    push_ts(32'h20);
    push_ts(32'h30);
    read_chk("fifo_status3", 5'h10, model_status(), 2'b00);
    for (int i = 0; i < 4; i++) begin
      read_chk("fifo_pop", 5'h14, (model_fifo.size() != 0) ? model_fifo.pop_front() : 32'hDEAD0000, 2'b00);
    end
    read_chk("fifo_status0", 5'h10, model_status(), 2'b00);
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 10; i++) push_ts(32'h100 + 32'(i) + ($urandom_range(0, 15) << 16));
    read_chk("ovf_status_set", 5'h10, model_status(), 2'b00);
    write_chk("ovf_clear_write", 5'h00, 32'h80000000, 4'hF, 2'b00);
    model_ovf = 1'b0;
    read_chk("ovf_status_clr", 5'h10, model_status(), 2'b00);
    n_checks++;
    if (ctrl_out !== 32'h80000000) begin
      n_errors++;
      $display("FAIL ovf_ctrl_out: got %h want 80000000", ctrl_out);
    end
    read_chk("ovf_oldest", 5'h14, model_fifo.pop_front(), 2'b00);
  endtask

  task automatic test_errors_and_reset();
    read_chk("err_unmapped_read", 5'h18, 32'h0, 2'b10);
    write_chk("err_status_write", 5'h10, 32'hFFFFFFFF, 4'hF, 2'b10);
    write_chk("err_pop_write", 5'h14, 32'hFFFFFFFF, 4'hF, 2'b10);
    read_chk("err_status_same", 5'h10, model_status(), 2'b00);
    // Reset in the middle of a read response.
    @(negedge clk);
    s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n_checks++;
    if (s_axi_rvalid !== 1'b1) begin n_errors++; $display("FAIL rst_mid_rvalid_up: got %b want 1", s_axi_rvalid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_axi_rvalid, s_axi_arready, s_axi_bvalid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_drop: got rvalid/arready/bvalid=%b want 000", {s_axi_rvalid, s_axi_arready, s_axi_bvalid});
    end
    model_fifo.delete();
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) read_chk("rst_mid_regs", 5'(i * 4), 32'h0, 2'b00);
    read_chk("rst_mid_status", 5'h10, model_status(), 2'b00);
    read_chk("rst_mid_fifo_empty", 5'h14, 32'hDEAD0000, 2'b00);
    n_checks++;
    if (ctrl_out !== 32'h0) begin n_errors++; $display("FAIL rst_mid_ctrl_out: got %h want 0", ctrl_out); end
  endtask

  initial begin
    test_reset();
    test_rw_basic();
    test_aw_before_w();
    test_wstrb();
    test_fifo_basic();
    test_fifo_overflow();
    test_errors_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
